// File: rtl/axi_time_pkg.sv
// rtl/axi_time_pkg.sv - shared types and constants for the timestamp trigger
package axi_time_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        PULSE = 2'd3
    } axi_time_trig_state_t;

    localparam int LATE_COUNT_WIDTH = 16;
    localparam int PULSE_CNT_WIDTH  = 8;

endpackage

// File: rtl/axi_time_sched_fifo.sv
// rtl/axi_time_sched_fifo.sv - in-order schedule queue, head word visible without a pop
module axi_time_sched_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full;
    logic             push_fire;
    logic             pop_fire;

    assign full       = (level_q == (AW+1)'(DEPTH));
    assign empty      = (level_q == '0);
    assign push_ready = ~full & ~flush;
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop & ~empty & ~flush;
    assign head_data  = mem_q[rd_ptr_q];
    assign level      = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_data;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + (AW+1)'(push_fire) - (AW+1)'(pop_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axi_time_trigger.sv
// rtl/axi_time_trigger.sv - fires a fixed-width pulse when the time counter reaches each queued target
module axi_time_trigger
    import axi_time_pkg::*;
#(
    parameter int COUNT_WIDTH = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int PULSE_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [COUNT_WIDTH-1:0]          time_counter,
    input  logic                            time_enable,
    input  logic                            sched_valid,
    output logic                            sched_ready,
    input  logic [COUNT_WIDTH-1:0]          sched_time,
    input  logic                            sched_flush,
    input  logic                            late_clear,
    output logic                            trigger_out,
    output logic [COUNT_WIDTH-1:0]          trigger_time,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [LATE_COUNT_WIDTH-1:0]     late_count,
    output logic                            late_error
);
    localparam logic [LATE_COUNT_WIDTH-1:0] LATE_MAX = {LATE_COUNT_WIDTH{1'b1}};

    axi_time_trig_state_t           state_q, state_d;
    logic [COUNT_WIDTH-1:0]         target_q, target_d;
    logic [COUNT_WIDTH-1:0]         trig_time_q, trig_time_d;
    logic                           trig_out_q, trig_out_d;
    logic [PULSE_CNT_WIDTH-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic [LATE_COUNT_WIDTH-1:0]    late_cnt_q, late_cnt_d;
    logic                           late_err_q, late_err_d;

    logic                           fifo_pop;
    logic                           fifo_empty;
    logic [COUNT_WIDTH-1:0]         fifo_head;
    logic                           hit;
    logic                           past;
    logic                           fire;
    logic                           late_event;
    logic                           pulse_end;
    logic [LATE_COUNT_WIDTH-1:0]    late_base;

    axi_time_sched_fifo #(
        .WIDTH (COUNT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (sched_flush),
        .push_valid (sched_valid),
        .push_ready (sched_ready),
        .push_data  (sched_time),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .level      (fifo_level),
        .empty      (fifo_empty)
    );

    // Plain unsigned compare: a wrap below the target counts as late.
    assign hit  = (time_counter == target_q);
    assign past = (time_counter > target_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sched_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = LOAD;
                LOAD:    state_d = ARMED;
                ARMED:   if (time_enable) begin
                             if (hit)       state_d = PULSE;
                             else if (past) state_d = IDLE;
                         end
                PULSE:   if (pulse_cnt_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_pop   = ~sched_flush & (state_q == LOAD);
        fire       = ~sched_flush & (state_q == ARMED) & time_enable & hit;
        late_event = ~sched_flush & (state_q == ARMED) & time_enable & ~hit & past;
        pulse_end  = (state_q == PULSE) & (pulse_cnt_q == '0);
    end

    always_comb begin
        target_d    = target_q;
        trig_time_d = trig_time_q;
        trig_out_d  = trig_out_q;
        pulse_cnt_d = pulse_cnt_q;
        if (fifo_pop) begin
            target_d = fifo_head;
        end
        if (sched_flush) begin
            trig_out_d  = 1'b0;
            pulse_cnt_d = '0;
        end else if (fire) begin
            trig_out_d  = 1'b1;
            trig_time_d = target_q;
            pulse_cnt_d = PULSE_CNT_WIDTH'(PULSE_WIDTH - 1);
        end else if (pulse_end) begin
            trig_out_d = 1'b0;
        end else if (state_q == PULSE) begin
            pulse_cnt_d = pulse_cnt_q - 1'b1;
        end

        // A late event in the same cycle as late_clear survives the clear.
        late_base  = late_clear ? '0 : late_cnt_q;
        late_cnt_d = late_base;
        late_err_d = late_clear ? 1'b0 : late_err_q;
        if (late_event) begin
            late_cnt_d = (late_base == LATE_MAX) ? late_base : late_base + 1'b1;
            late_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            target_q    <= '0;
            trig_time_q <= '0;
            trig_out_q  <= 1'b0;
            pulse_cnt_q <= '0;
            late_cnt_q  <= '0;
            late_err_q  <= 1'b0;
        end else begin
            target_q    <= target_d;
            trig_time_q <= trig_time_d;
            trig_out_q  <= trig_out_d;
            pulse_cnt_q <= pulse_cnt_d;
            late_cnt_q  <= late_cnt_d;
            late_err_q  <= late_err_d;
        end
    end

    assign trigger_out  = trig_out_q;
    assign trigger_time = trig_time_q;
    assign late_count   = late_cnt_q;
    assign late_error   = late_err_q;
    assign busy         = (fifo_level != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_axi_time_trigger.sv
// tb/tb_axi_time_trigger.sv - scoreboard bench for the timestamp trigger
module tb_axi_time_trigger;
    localparam int CW = 64;
    localparam int FD = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [CW-1:0] time_counter;
    logic          time_enable;
    logic          sched_valid;
    logic          sched_ready;
    logic [CW-1:0] sched_time;
    logic          sched_flush;
    logic          late_clear;
    logic          trigger_out;
    logic [CW-1:0] trigger_time;
    logic          busy;
    logic [2:0]    fifo_level;
    logic [15:0]   late_count;
    logic          late_error;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] exp_q [$];
    bit            width_chk = 1'b1;
    bit            prev_trig = 1'b0;
    int            hi_cnt = 0;

    always #5 clk = ~clk;

    axi_time_trigger #(
        .COUNT_WIDTH (CW),
        .FIFO_DEPTH  (FD),
        .PULSE_WIDTH (PW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .time_counter (time_counter),
        .time_enable  (time_enable),
        .sched_valid  (sched_valid),
        .sched_ready  (sched_ready),
        .sched_time   (sched_time),
        .sched_flush  (sched_flush),
        .late_clear   (late_clear),
        .trigger_out  (trigger_out),
        .trigger_time (trigger_time),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .late_count   (late_count),
        .late_error   (late_error)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The counter stage advances only while enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (time_enable) time_counter = time_counter + 1;
    endtask

    task automatic push(input logic [CW-1:0] t, input bit will_fire);
        bit acc = 1'b0;
        sched_valid = 1'b1;
        sched_time  = t;
        for (int i = 0; i < 50; i++) begin
            acc = sched_ready;
            tick();
            if (acc) break;
        end
        sched_valid = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
        else if (will_fire) exp_q.push_back(t);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic run_to(input logic [CW-1:0] c);
        for (int i = 0; i < 300 && time_counter < c; i++) tick();
    endtask

    always @(negedge clk) begin
        if (trigger_out && !prev_trig) begin
            if (exp_q.size() == 0) begin
                check("unexpected_trigger", 1, 0);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                check("trigger_time", trigger_time, e);
                check("rise_counter", time_counter, e + 1);
            end
            hi_cnt = 1;
        end else if (trigger_out) begin
            hi_cnt++;
        end else if (prev_trig && width_chk) begin
            check("pulse_width", hi_cnt, PW);
        end
        prev_trig = trigger_out;
    end

    initial begin
        resetn       = 1'b0;
        time_counter = '0;
        time_enable  = 1'b0;
        sched_valid  = 1'b0;
        sched_time   = '0;
        sched_flush  = 1'b0;
        late_clear   = 1'b0;
        repeat (3) tick();
        check("rst_trigger_out", trigger_out, 0);
        check("rst_sched_ready", sched_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_late_count", late_count, 0);
        check("rst_late_error", late_error, 0);
        check("rst_busy", busy, 0);
        check("rst_trigger_time", trigger_time, 0);
        resetn = 1'b1;
        tick();

        // single on-time event
        time_counter = 90;
        time_enable  = 1'b1;
        push(100, 1);
        wait_idle();
        check("t1_trigger_time", trigger_time, 100);
        check("t1_late_count", late_count, 0);
        check("t1_busy", busy, 0);

        // target already passed
        time_counter = 60;
        push(50, 0);
        wait_idle();
        check("t2_late_count", late_count, 1);
        check("t2_late_error", late_error, 1);
        late_clear = 1'b1;
        tick();
        late_clear = 1'b0;
        check("t2_clr_count", late_count, 0);
        check("t2_clr_error", late_error, 0);

        // fill the queue behind one armed entry
        time_counter = 0;
        push(200, 1);
        push(210, 1);
        push(220, 1);
        push(230, 1);
        push(240, 1);
        check("t3_ready_full", sched_ready, 0);
        check("t3_level_full", fifo_level, 4);
        wait_idle();
        check("t3_trigger_time", trigger_time, 240);
        check("t3_late_count", late_count, 0);

        // second target too close to the first
        time_counter = 290;
        push(300, 1);
        push(302, 0);
        wait_idle();
        check("t4_trigger_time", trigger_time, 300);
        check("t4_late_count", late_count, 1);

        // enable gating
        time_counter = 395;
        push(400, 1);
        run_to(400);
        time_enable = 1'b0;
        repeat (10) tick();
        check("t5_hold_no_pulse", trigger_out, 0);
        check("t5_hold_busy", busy, 1);
        time_enable = 1'b1;
        tick();
        check("t5_pulse_start", trigger_out, 1);
        wait_idle();

        // flush an armed and a queued entry
        time_counter = 440;
        push(500, 0);
        push(505, 0);
        run_to(450);
        sched_flush = 1'b1;
        tick();
        sched_flush = 1'b0;
        check("t5_flush_level", fifo_level, 0);
        check("t5_flush_busy", busy, 0);
        run_to(520);
        check("t5_flush_time", trigger_time, 400);
        check("t5_flush_late", late_count, 1);

        // reset during the second pulse cycle
        time_counter = 600;
        push(610, 1);
        push(700, 0);
        for (int i = 0; i < 100 && !trigger_out; i++) tick();
        check("t6_pulse_seen", trigger_out, 1);
        tick();
        width_chk = 1'b0;
        resetn = 1'b0;
        tick();
        check("t6_trigger_out", trigger_out, 0);
        check("t6_fifo_level", fifo_level, 0);
        check("t6_late_count", late_count, 0);
        check("t6_sched_ready", sched_ready, 1);
        check("t6_trigger_time", trigger_time, 0);
        resetn = 1'b1;
        repeat (3) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
